tt_sweep_ctrl: RTL

Sequencer that exhaustively characterises one 3-input, 1-output logic circuit under test (CUT), such as the gate-level score-calculation designs. It drives all eight input rows in turn, waits a settle window, samples the synchronised output several times, and assembles the 8-bit truth table in the team's hex notation (e.g. 0xB9). It compares the table against an expected value and flags unstable rows. It sits between the scoring testbench or host and the CUT instance.

---
 rtl/tt_sweep_pkg.sv | 20 ++
 rtl/tt_sweep_ctrl_sync2.sv | 26 ++
 rtl/tt_sweep_ctrl.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep controller.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } sweep_state_e;

  localparam int unsigned N_ROWS            = 8;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_SAMPLES       = 2;

  // Row 0 lands in the MSB of the truth table (team hex notation).
  function automatic logic [2:0] row_to_bit(input logic [2:0] r);
    return 3'(N_ROWS - 1) - r;
  endfunction

endpackage

// File: rtl/tt_sweep_ctrl_sync2.sv
// Two-flop synchroniser for the asynchronous CUT output.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[1];

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Sweeps all eight input rows of a 3-input CUT, samples its output and
// assembles the truth table, mismatch and per-row stability flags.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned SAMPLES       = DEF_SAMPLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] expected,
  output logic       busy,
  output logic       done,
  output logic       drv_in1,
  output logic       drv_in2,
  output logic       drv_in3,
  input  logic       obs_out,
  output logic [7:0] table_out,
  output logic [7:0] mismatch,
  output logic [7:0] unstable,
  output logic       pass
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > SAMPLES) ? SETTLE_CYCLES : SAMPLES;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  sweep_state_e     state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       table_q, table_d;
  logic [7:0]       mism_q, mism_d;
  logic [7:0]       unst_q, unst_d;
  logic [2:0]       drv_q, drv_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             obs_sync;
  logic [2:0]       bit_idx;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (obs_out),
    .q     (obs_sync)
  );

  assign bit_idx = row_to_bit(row_q);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    exp_d   = exp_q;
    table_d = table_q;
    mism_d  = mism_q;
    unst_d  = unst_q;
    drv_d   = drv_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    pass_d  = pass_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          row_d   = '0;
          cnt_d   = '0;
          exp_d   = expected;
          table_d = '0;
          mism_d  = '0;
          unst_d  = '0;
          pass_d  = 1'b0;
          drv_d   = '0;
          busy_d  = 1'b1;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAMPLE: begin
        // The first sample defines the table bit; later ones only vote on stability.
        if (cnt_q == '0) begin
          table_d[bit_idx] = obs_sync;
        end else if (obs_sync != table_q[bit_idx]) begin
          unst_d[bit_idx] = 1'b1;
        end
        if (cnt_q == CNT_W'(SAMPLES - 1)) begin
          cnt_d = '0;
          if (row_q == 3'(N_ROWS - 1)) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            mism_d  = table_d ^ exp_q;
            pass_d  = ((table_d ^ exp_q) == 8'h00) && (unst_d == 8'h00);
          end else begin
            state_d = SETTLE;
            row_d   = row_q + 1'b1;
            drv_d   = row_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      cnt_q   <= '0;
      exp_q   <= '0;
      table_q <= '0;
      mism_q  <= '0;
      unst_q  <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      table_q <= table_d;
      mism_q  <= mism_d;
      unst_q  <= unst_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign table_out = table_q;
  assign mismatch  = mism_q;
  assign unstable  = unst_q;
  assign drv_in1   = drv_q[2];
  assign drv_in2   = drv_q[1];
  assign drv_in3   = drv_q[0];

endmodule
